// File: rtl/acc_pkg.sv
// Shared state encoding and default plane geometry for the column accumulator controller.
package acc_pkg;
  localparam int WID_DEF  = 56;
  localparam int CHNL_DEF = 64;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } acc_state_t;
endpackage

// File: rtl/wrap_cnt.sv
// Modulo-MOD counter: clear has priority, advances on enable, o_wrap flags the last value.
// Zero latency on o_wrap (decoded from the registered count); no backpressure of its own.
module wrap_cnt #(
  parameter int MOD = 56,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + ONE;
    end
  end
endmodule

// File: rtl/acum_ctrl.sv
// Sequences channel-major column accumulation and hands finished columns downstream.
// Finished column valid one cycle after its last-channel accept; a stalled output blocks new columns.
module acum_ctrl
  import acc_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int CHNL = CHNL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             col_valid_i,
  output logic             col_ready_o,
  output logic             acc_en_o,
  output logic             acc_clr_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] chnl_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_col_o,
  output logic             busy,
  output logic             done
);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WID - 1);

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic             r_out_vld;
  logic [CNT_W-1:0] r_out_col;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_cnt_clr;
  logic             w_col_wrap;
  logic             w_chnl_wrap;
  logic             w_out_hs;
  logic             w_last_acc;
  logic             w_final_hs;

  // The single output holding register is the only buffer, so a stalled output stalls input.
  assign col_ready_o = (r_state == ST_ACCUM) && !(r_out_vld && !out_ready_i);
  assign acc_en_o    = col_valid_i && col_ready_o;
  assign acc_clr_o   = (r_state == ST_ACCUM) && (chnl_o == '0);
  assign w_out_hs    = r_out_vld && out_ready_i;
  assign w_last_acc  = acc_en_o && w_col_wrap && w_chnl_wrap;
  assign w_final_hs  = w_out_hs && (r_out_col == COL_LAST);

  assign out_valid_o = r_out_vld;
  assign out_col_o   = r_out_col;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;

  wrap_cnt #(.MOD(WID), .W(CNT_W)) u_col_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (acc_en_o),
    .i_clr  (w_cnt_clr),
    .o_cnt  (col_o),
    .o_wrap (w_col_wrap)
  );

  wrap_cnt #(.MOD(CHNL), .W(CNT_W)) u_chnl_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (acc_en_o && w_col_wrap),
    .i_clr  (w_cnt_clr),
    .o_cnt  (chnl_o),
    .o_wrap (w_chnl_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_cnt_clr   = abort;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_ACCUM;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_acc) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_final_hs) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A last-channel accept reloads the holding register even while it is being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_col <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (abort) begin
        r_out_vld <= 1'b0;
        r_out_col <= '0;
      end else if (acc_en_o && w_chnl_wrap) begin
        r_out_vld <= 1'b1;
        r_out_col <= col_o;
      end else if (w_out_hs) begin
        r_out_vld <= 1'b0;
      end
    end
  end
endmodule
